// File: rtl/led_scan.sv
// Eight-digit common-anode seven-segment scanner: internal scan tick, shadow/display
// double buffering committed at frame boundaries, optional leading-zero blanking.

module led_digit #(
   parameter int K = 0
) (
   input  logic [3:0] nib,
   input  logic       upper_zero,
   input  logic       blank_en,
   output logic [6:0] seg
);

   logic [6:0] hex;

   always_comb begin
      hex = 7'h7F;
      unique case (nib)
         4'h0: hex = 7'h40;
         4'h1: hex = 7'h79;
         4'h2: hex = 7'h24;
         4'h3: hex = 7'h30;
         4'h4: hex = 7'h19;
         4'h5: hex = 7'h12;
         4'h6: hex = 7'h02;
         4'h7: hex = 7'h78;
         4'h8: hex = 7'h00;
         4'h9: hex = 7'h10;
         4'hA: hex = 7'h08;
         4'hB: hex = 7'h03;
         4'hC: hex = 7'h46;
         4'hD: hex = 7'h21;
         4'hE: hex = 7'h06;
         4'hF: hex = 7'h0E;
      endcase
   end

   // Digit 0 always shows something, even when the whole value is zero.
   assign seg = (blank_en && upper_zero && (K != 0)) ? 7'h7F : hex;

endmodule

module led_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int DIGITS   = 8
) (
   input  logic        clk_board,
   input  logic        rst_n,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic        data_load,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [2:0]    IDX_MAX = 3'(DIGITS - 1);
   localparam logic [31:0]   VALID_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << (4 * DIGITS)) - 64'd1);

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  dp;
   } frame_t;

   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   frame_t          shadow, disp;
   logic            pending;
   logic            slot_end, frame_end;
   logic [31:0]     disp_vis;
   logic [7:0][6:0] seg_lane;
   logic [7:0]      an_next;

   assign slot_end  = (cnt == CNT_MAX);
   assign frame_end = slot_end && (idx == IDX_MAX);

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // A load coinciding with a commit lands in shadow after the old shadow
   // has been copied, so it stays pending for the following frame.
   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         shadow  <= '0;
         disp    <= '0;
         pending <= 1'b0;
      end else begin
         if (frame_end && pending)
            disp <= shadow;
         if (data_load) begin
            shadow  <= '{data: data_in, dp: dp_in};
            pending <= 1'b1;
         end else if (frame_end) begin
            pending <= 1'b0;
         end
      end
   end

   // Nibbles of digits that are never scanned must not defeat blanking.
   assign disp_vis = disp.data & VALID_MASK;

   for (genvar k = 0; k < 8; k++) begin : g_lane
      if (k < DIGITS) begin : g_on
         led_digit #(.K(k)) u_digit (
            .nib        (disp.data[4*k +: 4]),
            .upper_zero ((disp_vis >> (4 * k)) == 32'd0),
            .blank_en   (blank_lz),
            .seg        (seg_lane[k])
         );
      end else begin : g_off
         assign seg_lane[k] = 7'h7F;
      end
   end

   assign an_next = ~(8'd1 << idx);

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 8'hFF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         seg <= seg_lane[idx];
         dp  <= ~disp.dp[idx];
      end
   end

endmodule

// File: doc/led_scan.md
# led_scan

Time-multiplexed seven-segment display driver for the board's 8-digit common-anode display. It turns a 32-bit hex value into anode and segment drive, one digit per scan slot. It runs in the board clock domain and generates its own scan tick internally, so it needs no separately divided LED clock. Software-visible values are written through a load strobe and applied only at frame boundaries, so a digit never shows half of an old value and half of a new one.

## Interface
- SCAN_DIV, 50000: board-clock cycles per digit slot; legal values are 2 or more.
- DIGITS, 8: number of digits scanned, from 1 to 8; digits at or above DIGITS are never enabled.
- clk_board  in  1  board clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  32  value to display; nibble k drives digit k, and digit 0 is the rightmost.
- dp_in  in  8  decimal-point request per digit; 1 turns the point on.
- data_load  in  1  single-cycle strobe; captures data_in and dp_in into the shadow register.
- blank_lz  in  1  leading-zero blanking enable; sampled every cycle.
- an  out  8  anode enables, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- State:
  - scan counter cnt, range 0..SCAN_DIV-1
  - digit index idx, range 0..DIGITS-1
  - shadow data and shadow dp, plus a pending flag
  - display data and display dp
- Scan:
  - cnt increments on every clock.
  - When cnt = SCAN_DIV-1, cnt returns to 0 and idx advances. After DIGITS-1, idx wraps to 0.
- Load: when data_load = 1, shadow takes data_in and dp_in, and pending is set to 1.
- Frame commit: when cnt = SCAN_DIV-1, idx = DIGITS-1 and pending = 1:
  - display takes the shadow contents and pending clears.
  - If data_load is also high in that same cycle, the commit uses the shadow value from before the load. The shadow then takes the new data and pending stays at 1, so the new value commits at the next frame.
- Output, registered every clock from the current idx and display contents:
  - an[idx] = 0 and every other anode bit = 1.
  - seg is the hex decode of nibble idx.
  - dp = ~display_dp[idx].
- Hex decode, 0..F, in gfedcba order:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Leading-zero blanking, when blank_lz = 1:
  - A digit k ≥ 1 is blanked if nibble k and every higher nibble below DIGITS are all zero.
  - A blanked digit drives seg = 1111111, but its anode is still driven and dp still follows display_dp[idx].
  - Digit 0 is never blanked.
- An idle frame (pending = 0) leaves the display contents unchanged indefinitely.

## Timing
- Reset values:
  - an = 8'hFF, seg = 7'h7F, dp = 1
  - cnt = 0, idx = 0
  - shadow = 0, display = 0, dp registers = 0, pending = 0
- First edge after reset release: an = FE, seg = 1000000 (digit 0 shows "0").
- Output latency is 1 cycle after each idx change.
  - A new digit appears on the clock after the cnt = SCAN_DIV-1 edge.
  - Each digit is lit for exactly SCAN_DIV cycles.
- Frame period is DIGITS × SCAN_DIV cycles.
- Worst-case delay from data_load to visible output is about 2 frames + 1 cycle.
- Asserting rst_n low mid-scan forces all outputs to their reset values immediately (asynchronously); any pending load is discarded.
- an is never all-zero and never has two bits low at once, including across wrap.

## Test plan
- Reset, then idle, with SCAN_DIV = 4 and DIGITS = 8:
  - an cycles FE, FD, FB, … 7F, FE, each held 4 cycles.
  - seg on every digit = 1000000.
- Load 0x1234ABCD with dp_in = 0x01 while blank_lz = 0:
  - From the next frame, digit 0 = d (0100001) with dp = 0.
  - Digit 7 = 1 (1111001).
  - The value is unchanged before the commit edge.
- blank_lz = 1 with value 0x000000F0:
  - Digit 0 shows 1000000 and digit 1 shows F (0001110).
  - Digits 2–7 show seg = 7F while their anodes still rotate.
- data_load in the commit cycle: load 0x11111111, then 0x22222222 exactly at cnt = 3, idx = 7:
  - 0x11111111 is displayed for one full frame.
  - 0x22222222 is displayed after the next frame commit.
- Reset pulse mid-frame (idx = 5) with pending set:
  - an = FF and seg = 7F asynchronously.
  - After release, the scan restarts at FE and the display shows 0.
- DIGITS = 4:
  - an cycles only FE, FD, FB, F7.
  - an[7:4] stays at 1 throughout.
